ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- instruction sequencing controller for a small register-file
// datapath.
//
// Purpose:
//   Fetches an instruction word when instr_valid is high and latches it in
//   DECODE. It then steps through one to three execute states and drives the
//   datapath selects and strobes for each step. Every output is registered.
//   Because of that, the outputs a state computes become visible in the cycle
//   after that state.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (state -> FETCH, outputs -> 0)
//   instr        instruction word; instr_valid qualifies it in FETCH
//   z            ALU zero flag, consulted by JMPZ in EX1
//   ir_load      one-cycle pulse: capture instruction / advance PC
//   alu_op       00 none, 01 add, 10 sub, 11 mul
//   m1           register write source: 01 mem/imm, 10 alpha, 11 ALU
//   m2, m3, m4   datapath mux selects (m3 = 1: PC loads gamma)
//   rpa/rpb/wpn  read port A, read port B, write port addresses
//   write_en, write_dram, rst_en   one-cycle strobes
//   alpha        immediate field; gamma  jump target field
//   halted       END executed (left only by reset)
//   illegal      one-cycle pulse on an undefined opcode
module ctrl_fsm #(
  parameter int IW   = 20,
  parameter int OPW  = 4,
  parameter int RAW  = 4,
  parameter int IMMW = 12,
  parameter int TGTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  input  logic            z,
  output logic            ir_load,
  output logic [1:0]      alu_op,
  output logic [1:0]      m1,
  output logic            m2,
  output logic            m3,
  output logic            m4,
  output logic [RAW-1:0]  rpa,
  output logic [RAW-1:0]  rpb,
  output logic [RAW-1:0]  wpn,
  output logic            write_en,
  output logic            write_dram,
  output logic            rst_en,
  output logic [IMMW-1:0] alpha,
  output logic [TGTW-1:0] gamma,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {FETCH, DECODE, EX1, EX2, EX3, HALT} state_t;

  localparam logic [OPW-1:0] OP_RST   = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_WRITE = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_LOADI = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_MV    = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_INC   = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(4'hC);
  localparam logic [OPW-1:0] OP_STORE = OPW'(4'hD);
  localparam logic [OPW-1:0] OP_END   = OPW'(4'hE);

  state_t          state, state_nx;
  logic [IW-1:0]   ir;

  // Decode fields: the live word in DECODE, the latched copy in EX states.
  logic [OPW-1:0]  op_in, op;
  logic [RAW-1:0]  fa, fb;
  logic [IMMW-1:0] imm;
  logic [TGTW-1:0] tgt;

  assign op_in = instr[IW-1 -: OPW];
  assign op    = ir[IW-1 -: OPW];
  assign fa    = ir[IW-OPW-1 -: RAW];
  assign fb    = ir[IW-OPW-RAW-1 -: RAW];
  assign imm   = ir[IMMW-1:0];
  assign tgt   = ir[IW-OPW-1 -: TGTW];

  // Next values of the registered outputs.
  logic            ir_load_d, m2_d, m3_d, m4_d;
  logic [1:0]      alu_op_d, m1_d;
  logic [RAW-1:0]  rpa_d, rpb_d, wpn_d;
  logic            write_en_d, write_dram_d, rst_en_d, halted_d, illegal_d;
  logic [IMMW-1:0] alpha_d;
  logic [TGTW-1:0] gamma_d;

  function automatic logic is_defined(input logic [OPW-1:0] o);
    return (o >= OP_RST) && (o <= OP_END);
  endfunction

  // The instruction register holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == DECODE) ir <= instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      ir_load    <= 1'b0;
      alu_op     <= '0;
      m1         <= '0;
      m2         <= 1'b0;
      m3         <= 1'b0;
      m4         <= 1'b0;
      rpa        <= '0;
      rpb        <= '0;
      wpn        <= '0;
      write_en   <= 1'b0;
      write_dram <= 1'b0;
      rst_en     <= 1'b0;
      alpha      <= '0;
      gamma      <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_nx;
      ir_load    <= ir_load_d;
      alu_op     <= alu_op_d;
      m1         <= m1_d;
      m2         <= m2_d;
      m3         <= m3_d;
      m4         <= m4_d;
      rpa        <= rpa_d;
      rpb        <= rpb_d;
      wpn        <= wpn_d;
      write_en   <= write_en_d;
      write_dram <= write_dram_d;
      rst_en     <= rst_en_d;
      alpha      <= alpha_d;
      gamma      <= gamma_d;
      halted     <= halted_d;
      illegal    <= illegal_d;
    end
  end

  always_comb begin
    // Strobes default low. Selects and fields hold until reassigned.
    state_nx     = state;
    ir_load_d    = 1'b0;
    m3_d         = 1'b0;
    write_en_d   = 1'b0;
    write_dram_d = 1'b0;
    rst_en_d     = 1'b0;
    illegal_d    = 1'b0;
    alu_op_d     = alu_op;
    m1_d         = m1;
    m2_d         = m2;
    m4_d         = m4;
    rpa_d        = rpa;
    rpb_d        = rpb;
    wpn_d        = wpn;
    alpha_d      = alpha;
    gamma_d      = gamma;
    halted_d     = halted;

    unique case (state)
      FETCH: begin
        if (instr_valid) begin
          ir_load_d = 1'b1;
          state_nx  = DECODE;
        end
      end

      DECODE: begin
        if (op_in == OP_END) begin
          halted_d = 1'b1;
          state_nx = HALT;
        end else if (is_defined(op_in)) begin
          state_nx = EX1;
        end else begin
          illegal_d = 1'b1;
          state_nx  = FETCH;
        end
      end

      EX1: begin
        state_nx = FETCH;
        case (op)
          OP_RST:   begin rst_en_d = 1'b1; wpn_d = fa; end
          OP_WRITE: begin write_en_d = 1'b1; wpn_d = fa; alpha_d = imm; m1_d = 2'b10; end
          OP_MUL:   begin alu_op_d = 2'b11; rpa_d = fa; rpb_d = fb; end
          OP_ADD:   begin alu_op_d = 2'b01; rpa_d = fa; rpb_d = fb; end
          OP_SUB:   begin alu_op_d = 2'b10; rpa_d = fa; rpb_d = fb; end
          OP_MV:    begin m1_d = 2'b11; wpn_d = fa; write_en_d = 1'b1; end
          OP_JMP:   begin gamma_d = tgt; m3_d = 1'b1; end
          OP_JMPZ:  begin gamma_d = tgt; m3_d = z; end
          OP_INC: begin
            rpa_d    = fa;
            rpb_d    = '1;
            alu_op_d = 2'b01;
            state_nx = EX2;
          end
          OP_STORE: begin m4_d = 1'b1; rpa_d = fb; state_nx = EX2; end
          OP_LOADI: begin alpha_d = imm; m4_d = 1'b0; state_nx = EX2; end
          OP_LOAD:  begin m4_d = 1'b1; rpa_d = fb; state_nx = EX2; end
          default:  state_nx = FETCH;
        endcase
      end

      EX2: begin
        state_nx = FETCH;
        case (op)
          OP_INC:   begin m1_d = 2'b11; wpn_d = fa; write_en_d = 1'b1; end
          OP_STORE: begin rpb_d = fa; m2_d = 1'b0; write_dram_d = 1'b1; end
          OP_LOADI,
          OP_LOAD:  begin m2_d = 1'b1; state_nx = EX3; end
          default:  state_nx = FETCH;
        endcase
      end

      EX3: begin
        // Only LOADI and LOAD reach EX3; both finish with the same writeback.
        m1_d       = 2'b01;
        wpn_d      = fa;
        write_en_d = 1'b1;
        state_nx   = FETCH;
      end

      HALT: state_nx = HALT;

      default: state_nx = FETCH;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Testbench for ctrl_fsm: directed instruction sequence, with expected output
// snapshots queued as stimulus is driven and compared one cycle later.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] instr;
  logic        instr_valid, z;
  logic        ir_load, m2, m3, m4, write_en, write_dram, rst_en, halted, illegal;
  logic [1:0]  alu_op, m1;
  logic [3:0]  rpa, rpb, wpn;
  logic [11:0] alpha;
  logic [5:0]  gamma;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .z(z),
    .ir_load(ir_load), .alu_op(alu_op), .m1(m1), .m2(m2), .m3(m3), .m4(m4),
    .rpa(rpa), .rpb(rpb), .wpn(wpn), .write_en(write_en),
    .write_dram(write_dram), .rst_en(rst_en), .alpha(alpha), .gamma(gamma),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_load;
    logic [1:0] alu_op;
    logic [1:0] m1;
    logic       m2, m3, m4;
    logic [3:0] rpa, rpb, wpn;
    logic       write_en, write_dram, rst_en;
    logic [11:0] alpha;
    logic [5:0] gamma;
    logic       halted, illegal;
  } outs_t;

  outs_t obs, e;
  outs_t q[$];
  int tests = 0;
  int fails = 0;

  assign obs = {ir_load, alu_op, m1, m2, m3, m4, rpa, rpb, wpn,
                write_en, write_dram, rst_en, alpha, gamma, halted, illegal};

  task automatic compare(input string tag);
    outs_t x;
    x = q.pop_front();
    tests++;
    assert (obs === x) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, x);
    end
  endtask

  task automatic clr_strobes();
    e.ir_load = 1'b0; e.m3 = 1'b0; e.write_en = 1'b0;
    e.write_dram = 1'b0; e.rst_en = 1'b0; e.illegal = 1'b0;
  endtask

  // Queue the expectation, advance one clock, compare off the edge.
  task automatic tick(input string tag);
    q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
    clr_strobes();
  endtask

  task automatic check_now(input string tag);
    q.push_back(e);
    #1;
    compare(tag);
  endtask

  // FETCH with valid, then DECODE; instr is scrambled afterwards so later
  // stages can only see the latched copy.
  task automatic issue(input logic [19:0] w, input string tag);
    logic [3:0] o;
    o = w[19:16];
    instr = w;
    instr_valid = 1'b1;
    e.ir_load = 1'b1;
    tick({tag, "_irload"});
    instr_valid = 1'b0;
    if (o == 4'h0 || o == 4'h1 || o == 4'hF) e.illegal = 1'b1;
    if (o == 4'hE) e.halted = 1'b1;
    tick({tag, "_decode"});
    instr = 20'($urandom);
  endtask

  initial begin
    rst = 1'b1; instr = 20'h0; instr_valid = 1'b0; z = 1'b0;
    e = '0;
    check_now("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    tick("idle0");

    // ADD A=3 B=5
    issue(20'h83512, "add");
    e.alu_op = 2'b01; e.rpa = 4'd3; e.rpb = 4'd5;
    tick("add_ex1");

    // RST A=9 (its ir_load lands 3 cycles after the ADD ir_load)
    issue(20'h29000, "rst");
    e.rst_en = 1'b1; e.wpn = 4'd9;
    tick("rst_ex1");
    tick("rst_after");

    // WRITE A=4 imm=0x5A3
    issue(20'h345A3, "write");
    e.write_en = 1'b1; e.wpn = 4'd4; e.alpha = 12'h5A3; e.m1 = 2'b10;
    tick("write_ex1");

    // MUL A=1 B=2, SUB A=6 B=7
    issue(20'h51200, "mul");
    e.alu_op = 2'b11; e.rpa = 4'd1; e.rpb = 4'd2;
    tick("mul_ex1");
    issue(20'hA6700, "sub");
    e.alu_op = 2'b10; e.rpa = 4'd6; e.rpb = 4'd7;
    tick("sub_ex1");

    // MV A=C
    issue(20'h7C000, "mv");
    e.m1 = 2'b11; e.wpn = 4'hC; e.write_en = 1'b1;
    tick("mv_ex1");

    // INC A=5
    issue(20'h95000, "inc");
    e.rpa = 4'd5; e.rpb = 4'hF; e.alu_op = 2'b01;
    tick("inc_ex1");
    e.m1 = 2'b11; e.wpn = 4'd5; e.write_en = 1'b1;
    tick("inc_ex2");

    // STORE A=2 B=8
    issue(20'hD2800, "store");
    e.m4 = 1'b1; e.rpa = 4'd8;
    tick("store_ex1");
    e.rpb = 4'd2; e.m2 = 1'b0; e.write_dram = 1'b1;
    tick("store_ex2");

    // LOADI A=7 imm=0xABC
    issue(20'h47ABC, "loadi");
    e.alpha = 12'hABC; e.m4 = 1'b0;
    tick("loadi_ex1");
    e.m2 = 1'b1;
    tick("loadi_ex2");
    e.m1 = 2'b01; e.wpn = 4'd7; e.write_en = 1'b1;
    tick("loadi_ex3");
    tick("loadi_after");

    // LOAD A=3 B=E
    issue(20'h63E00, "load");
    e.m4 = 1'b1; e.rpa = 4'hE;
    tick("load_ex1");
    e.m2 = 1'b1;
    tick("load_ex2");
    e.m1 = 2'b01; e.wpn = 4'd3; e.write_en = 1'b1;
    tick("load_ex3");

    // JMP 0x15, JMPZ 0x2A with z=0, JMP 0x15, JMPZ 0x2A with z=1
    issue(20'hC5400, "jmp1");
    e.gamma = 6'h15; e.m3 = 1'b1;
    tick("jmp1_ex1");
    z = 1'b0;
    issue(20'hBA800, "jmpz0");
    e.gamma = 6'h2A;
    tick("jmpz0_ex1");
    tick("jmpz0_after");
    issue(20'hC5400, "jmp2");
    e.gamma = 6'h15; e.m3 = 1'b1;
    tick("jmp2_ex1");
    z = 1'b1;
    issue(20'hBA800, "jmpz1");
    e.gamma = 6'h2A; e.m3 = 1'b1;
    tick("jmpz1_ex1");
    tick("jmpz1_after");
    z = 1'b0;

    // Reset while LOADI sits in EX2
    issue(20'h47ABC, "loadi_rst");
    e.alpha = 12'hABC; e.m4 = 1'b0;
    tick("loadi_rst_ex1");
    rst = 1'b1;
    e = '0;
    check_now("rst_in_ex2");
    @(posedge clk); #1;
    rst = 1'b0;
    tick("rst_ex2_after1");
    tick("rst_ex2_after2");

    // instr_valid low for 5 cycles, then an undefined opcode
    instr = 20'h01234;
    for (int i = 0; i < 5; i++) tick("valid_low");
    issue(20'h01234, "illegal");
    tick("illegal_after");

    // END, then 20 cycles of instr_valid high
    issue(20'hE0000, "end");
    instr_valid = 1'b1;
    instr = 20'h83512;
    for (int i = 0; i < 20; i++) tick("halted_hold");
    instr_valid = 1'b0;
    rst = 1'b1;
    e = '0;
    check_now("halt_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    tick("post_halt_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
